vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side timing master for the 640x480 block-grid display.
- Generates `horizCount`/`vertCount` for the graphics generator and accepts its combinational `{red,green,blue}` pixel colour back.
- Drives the VGA DAC pins and sync outputs, re-aligning sync and blanking to the generator's pipeline latency.
- Issues a once-per-frame tick that game logic uses to update blockieee, DDAVER and BulletBill state.

Parameters:
- HPIXELS, 640, visible pixels per line
- HFRONT, 16, horizontal front porch (pixels)
- HSYNC, 96, horizontal sync width (pixels)
- HBACK, 48, horizontal back porch (pixels)
- VPIXELS, 480, visible lines per frame
- VFRONT, 10, vertical front porch (lines)
- VSYNC, 2, vertical sync width (lines)
- VBACK, 33, vertical back porch (lines)
- PIPE_DELAY, 1, clk-enabled pixel ticks from count presentation to registered colour output; range 1..4

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pixelEnable  input  1  pixel-rate strobe (25 MHz equivalent); all timing advances only on clk edges where high
- horizCount  output  10  current pixel column 0..799, to graphics generator
- vertCount  output  10  current line 0..524, to graphics generator
- pixelColor  input  12  {red[3:0],green[3:0],blue[3:0]} from generator for current counts
- vgaRed  output  4  DAC red
- vgaGreen  output  4  DAC green
- vgaBlue  output  4  DAC blue
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- frameStart  output  1  one-clk pulse at start of each frame
- vblank  output  1  high while vertCount >= VPIXELS (undelayed)

Behaviour:
- Totals: HTOTAL = HPIXELS+HFRONT+HSYNC+HBACK = 800; VTOTAL = 525. Widths are fixed at 10 bits; HTOTAL and VTOTAL must be <= 1024.
- Reset (synchronous, any cycle): horizCount=0, vertCount=0; all delay stages cleared to inactive (active=0, hsync=1, vsync=1); vgaRed/Green/Blue=0; hsync=1, vsync=1, frameStart=0. Reset dominates pixelEnable.
- Counting, on a clk edge with pixelEnable=1:
  - horizCount increments.
  - At HTOTAL-1 it wraps to 0 and vertCount increments.
  - vertCount at VTOTAL-1, together with horizCount wrap, wraps to 0.
- pixelEnable=0: counters, delay line and all outputs hold, except frameStart, which returns to 0.
- Raw timing, combinational from the counters:
  - active = horizCount<HPIXELS && vertCount<VPIXELS
  - hs_n = !(HPIXELS+HFRONT <= horizCount < HPIXELS+HFRONT+HSYNC), i.e. low for 656..751
  - vs_n = !(VPIXELS+VFRONT <= vertCount < VPIXELS+VFRONT+VSYNC), i.e. low for 490..491
- Delay line: a PIPE_DELAY-deep shift register of {active, hs_n, vs_n}, advancing on enabled ticks. Stage 0 captures the raw values; the final stage drives hsync/vsync.
- Colour capture: pixelColor is sampled on an enabled tick into a register chain of PIPE_DELAY-1 extra stages, so the colour stays aligned with the delayed active bit.
- Blanking: output RGB = aligned colour when delayed active=1, else 0. Blanking is mandatory regardless of pixelColor.
- Latency: counts at (h,v) appear on vgaRed/Green/Blue and hsync after exactly PIPE_DELAY enabled ticks.
- frameStart: 1 for exactly one clk cycle, on the enabled edge where the counters go from (799,524) to (0,0). It is not asserted on reset release.
- Reset mid-frame: the next frame starts at (0,0) with no partial-sync glitch; sync outputs stay 1 during reset.
- Counter beyond range (unreachable in normal operation): next enabled tick forces wrap to 0.

Decomposition:
- Shared package `vga_pkg`:
  - timing localparams (HPIXELS, VPIXELS, porch and sync values, HTOTAL, VTOTAL, BSIZE=40)
  - `rgb12_t` packed struct {r,g,b} of 4 bits each
  - `count_t` = logic[9:0]
- Natural sub-module: `vga_timing_counter`, holding the h/v counters, wrap logic, raw active/hs_n/vs_n decode and the frameStart pulse. `vga_scanout` wraps it with the delay line and the blanking mux.

Test Plan:
- Reset with pixelEnable=1 for 3 clks, then release -> counts (0,0), hsync=vsync=1, RGB=0, frameStart never 1 until the first full-frame wrap.
- pixelEnable always 1, pixelColor=12'hF0A -> hsync low for exactly 96 ticks starting PIPE_DELAY ticks after horizCount=656; line period 800 ticks; vsync low 1600 ticks per 420000-tick frame.
- pixelColor driven as {horizCount[3:0],vertCount[3:0],4'h5} -> at the output, RGB equals that of the counts PIPE_DELAY ticks earlier; RGB=0 for all horizCount>=640 or vertCount>=480 despite nonzero input.
- pixelEnable pulsing 1-of-4 clks -> identical output sequence per enabled tick as the always-enabled case; frameStart width exactly 1 clk; outputs stable across disabled clks.
- Assert reset at (h=300,v=200) for 1 clk -> next enabled tick shows counts (1,0); hsync=vsync=1 in the reset cycle; no frameStart.
- Run 2 full frames -> frameStart pulses exactly twice, 420000 enabled ticks apart; vblank high for lines 480..524 only.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480 block-grid scanout path.
package vga_pkg;

  localparam int HPIXELS    = 640;
  localparam int HFRONT     = 16;
  localparam int HSYNC      = 96;
  localparam int HBACK      = 48;
  localparam int VPIXELS    = 480;
  localparam int VFRONT     = 10;
  localparam int VSYNC      = 2;
  localparam int VBACK      = 33;
  localparam int HTOTAL     = HPIXELS + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL     = VPIXELS + VFRONT + VSYNC + VBACK;
  localparam int BSIZE      = 40;
  localparam int PIPE_DELAY = 1;

  typedef logic [9:0] count_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical scan counters with raw sync/active decode and the
// once-per-frame tick used by the game logic.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int HPIXELS = vga_pkg::HPIXELS,
  parameter int HFRONT  = vga_pkg::HFRONT,
  parameter int HSYNC   = vga_pkg::HSYNC,
  parameter int HBACK   = vga_pkg::HBACK,
  parameter int VPIXELS = vga_pkg::VPIXELS,
  parameter int VFRONT  = vga_pkg::VFRONT,
  parameter int VSYNC   = vga_pkg::VSYNC,
  parameter int VBACK   = vga_pkg::VBACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_enable,
  output logic [9:0] horiz_count,
  output logic [9:0] vert_count,
  output logic       active,
  output logic       hs_n,
  output logic       vs_n,
  output logic       frame_start,
  output logic       vblank
);

  localparam count_t H_LAST    = count_t'(HPIXELS + HFRONT + HSYNC + HBACK - 1);
  localparam count_t V_LAST    = count_t'(VPIXELS + VFRONT + VSYNC + VBACK - 1);
  localparam count_t H_VISIBLE = count_t'(HPIXELS);
  localparam count_t V_VISIBLE = count_t'(VPIXELS);
  localparam count_t HS_START  = count_t'(HPIXELS + HFRONT);
  localparam count_t HS_END    = count_t'(HPIXELS + HFRONT + HSYNC);
  localparam count_t VS_START  = count_t'(VPIXELS + VFRONT);
  localparam count_t VS_END    = count_t'(VPIXELS + VFRONT + VSYNC);

  count_t h_q, h_d;
  count_t v_q, v_d;
  logic   frame_start_q, frame_start_d;

  // Out-of-range counts (never reached normally) fall back to 0 on the next tick.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (pixel_enable) begin
      if (h_q >= H_LAST) begin
        h_d = '0;
        if (v_q >= V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
        if (v_q > V_LAST) begin
          v_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign horiz_count = h_q;
  assign vert_count  = v_q;
  assign active      = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
  assign hs_n        = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_n        = !((v_q >= VS_START) && (v_q < VS_END));
  assign frame_start = frame_start_q;
  assign vblank      = (v_q >= V_VISIBLE);

endmodule

// File: rtl/vga_scanout.sv
// VGA timing master: presents scan counts to the graphics generator and
// re-aligns sync/blanking with its colour after PIPE_DELAY pixel ticks.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int HPIXELS    = vga_pkg::HPIXELS,
  parameter int HFRONT     = vga_pkg::HFRONT,
  parameter int HSYNC      = vga_pkg::HSYNC,
  parameter int HBACK      = vga_pkg::HBACK,
  parameter int VPIXELS    = vga_pkg::VPIXELS,
  parameter int VFRONT     = vga_pkg::VFRONT,
  parameter int VSYNC      = vga_pkg::VSYNC,
  parameter int VBACK      = vga_pkg::VBACK,
  parameter int PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelEnable,
  output logic [9:0]  horizCount,
  output logic [9:0]  vertCount,
  input  logic [11:0] pixelColor,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync,
  output logic        frameStart,
  output logic        vblank
);

  logic raw_active, raw_hs_n, raw_vs_n;

  vga_timing_counter #(
    .HPIXELS (HPIXELS),
    .HFRONT  (HFRONT),
    .HSYNC   (HSYNC),
    .HBACK   (HBACK),
    .VPIXELS (VPIXELS),
    .VFRONT  (VFRONT),
    .VSYNC   (VSYNC),
    .VBACK   (VBACK)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .pixel_enable (pixelEnable),
    .horiz_count  (horizCount),
    .vert_count   (vertCount),
    .active       (raw_active),
    .hs_n         (raw_hs_n),
    .vs_n         (raw_vs_n),
    .frame_start  (frameStart),
    .vblank       (vblank)
  );

  timing_t [PIPE_DELAY-1:0] timing_q, timing_d;
  rgb12_t  [PIPE_DELAY-1:0] color_q, color_d;
  rgb12_t                   rgb_out;

  // Timing bits and colour shift side by side so the last stage of each
  // always describes the same scan position.
  always_comb begin
    timing_d = timing_q;
    color_d  = color_q;
    if (pixelEnable) begin
      timing_d[0] = '{active: raw_active, hs_n: raw_hs_n, vs_n: raw_vs_n};
      color_d[0]  = rgb12_t'(pixelColor);
      for (int i = 1; i < PIPE_DELAY; i++) begin
        timing_d[i] = timing_q[i-1];
        color_d[i]  = color_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        timing_q[i] <= TIMING_IDLE;
        color_q[i]  <= '0;
      end
    end else begin
      timing_q <= timing_d;
      color_q  <= color_d;
    end
  end

  assign rgb_out  = timing_q[PIPE_DELAY-1].active ? color_q[PIPE_DELAY-1] : '0;
  assign vgaRed   = rgb_out.r;
  assign vgaGreen = rgb_out.g;
  assign vgaBlue  = rgb_out.b;
  assign hsync    = timing_q[PIPE_DELAY-1].hs_n;
  assign vsync    = timing_q[PIPE_DELAY-1].vs_n;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout: a full-size instance and a shrunken-timing
// instance are compared every clock against a tick-count based reference.
module tb_vga_scanout;

  localparam int A_HP = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VP = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_PD = 1;
  localparam int A_HT = A_HP + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VP + A_VF + A_VS + A_VB;
  localparam int B_HP = 20, B_HF = 3, B_HS = 4, B_HB = 5;
  localparam int B_VP = 6,  B_VF = 2, B_VS = 2, B_VB = 3, B_PD = 3;
  localparam int B_HT = B_HP + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VP + B_VF + B_VS + B_VB;
  localparam int LOG_DEPTH = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_enable = 1'b0;
  logic        color_fixed = 1'b0;
  logic [11:0] color_mask = 12'h000;

  logic [9:0]  a_horiz, a_vert, b_horiz, b_vert;
  logic [11:0] a_color, b_color;
  logic [3:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic        a_hsync, a_vsync, a_fs, a_vblank;
  logic        b_hsync, b_vsync, b_fs, b_vblank;

  int          checks = 0;
  int          errors = 0;
  int          ticks = 0;
  logic        exp_fs_a, exp_fs_b;
  logic [12:0] color_log [LOG_DEPTH];

  always #5 clk = ~clk;

  // Generator stand-in: either a fixed colour or a count-derived pattern.
  assign a_color = color_fixed ? 12'hF0A : ({a_horiz[3:0], a_vert[3:0], 4'h5} ^ color_mask);
  assign b_color = color_fixed ? 12'hF0A : ({b_horiz[3:0], b_vert[3:0], 4'h5} ^ color_mask);

  vga_scanout #(
    .HPIXELS(A_HP), .HFRONT(A_HF), .HSYNC(A_HS), .HBACK(A_HB),
    .VPIXELS(A_VP), .VFRONT(A_VF), .VSYNC(A_VS), .VBACK(A_VB), .PIPE_DELAY(A_PD)
  ) dut_a (
    .clk(clk), .reset(reset), .pixelEnable(pixel_enable),
    .horizCount(a_horiz), .vertCount(a_vert), .pixelColor(a_color),
    .vgaRed(a_red), .vgaGreen(a_green), .vgaBlue(a_blue),
    .hsync(a_hsync), .vsync(a_vsync), .frameStart(a_fs), .vblank(a_vblank)
  );

  vga_scanout #(
    .HPIXELS(B_HP), .HFRONT(B_HF), .HSYNC(B_HS), .HBACK(B_HB),
    .VPIXELS(B_VP), .VFRONT(B_VF), .VSYNC(B_VS), .VBACK(B_VB), .PIPE_DELAY(B_PD)
  ) dut_b (
    .clk(clk), .reset(reset), .pixelEnable(pixel_enable),
    .horizCount(b_horiz), .vertCount(b_vert), .pixelColor(b_color),
    .vgaRed(b_red), .vgaGreen(b_green), .vgaBlue(b_blue),
    .hsync(b_hsync), .vsync(b_vsync), .frameStart(b_fs), .vblank(b_vblank)
  );

  // Expected outputs after `n` enabled ticks since reset: counts are n mod the
  // raster, the pins show the scan position n-pd with the colour logged then.
  function automatic logic [35:0] expectOut(input int hp, input int hf, input int hsw,
                                            input int ht, input int vp, input int vf,
                                            input int vsw, input int vt, input int pd,
                                            input int n, input logic fs);
    int          h, v, c, ch, cv;
    logic        hs_n, vs_n;
    logic [11:0] col;
    logic [12:0] entry;
    h    = n % ht;
    v    = (n / ht) % vt;
    col  = 12'h000;
    hs_n = 1'b1;
    vs_n = 1'b1;
    if (n >= pd) begin
      c     = n - pd;
      ch    = c % ht;
      cv    = (c / ht) % vt;
      hs_n  = !(ch >= hp + hf && ch < hp + hf + hsw);
      vs_n  = !(cv >= vp + vf && cv < vp + vf + vsw);
      entry = color_log[c % LOG_DEPTH];
      if (ch < hp && cv < vp)
        col = entry[12] ? 12'hF0A : ({4'(ch), 4'(cv), 4'h5} ^ entry[11:0]);
    end
    return {10'(h), 10'(v), col, hs_n, vs_n, fs, (v >= vp)};
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] observed,
                             input logic [35:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h (tick %0d, time %0t)",
               tag, observed, expected, ticks, $time);
    end
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare #1 later.
  task automatic applyStimulus(input logic rst, input logic en, input logic fixed,
                               input logic [11:0] mask);
    @(negedge clk);
    reset        = rst;
    pixel_enable = en;
    color_fixed  = fixed;
    color_mask   = mask;
    @(posedge clk);
    exp_fs_a = 1'b0;
    exp_fs_b = 1'b0;
    if (rst) begin
      ticks = 0;
    end else if (en) begin
      color_log[ticks % LOG_DEPTH] = {fixed, mask};
      ticks++;
      exp_fs_a = (ticks % (A_HT * A_VT)) == 0;
      exp_fs_b = (ticks % (B_HT * B_VT)) == 0;
    end
    #1;
    checkOutput("dut_a", {a_horiz, a_vert, a_red, a_green, a_blue, a_hsync, a_vsync, a_fs, a_vblank},
                expectOut(A_HP, A_HF, A_HS, A_HT, A_VP, A_VF, A_VS, A_VT, A_PD, ticks, exp_fs_a));
    checkOutput("dut_b", {b_horiz, b_vert, b_red, b_green, b_blue, b_hsync, b_vsync, b_fs, b_vblank},
                expectOut(B_HP, B_HF, B_HS, B_HT, B_VP, B_VF, B_VS, B_VT, B_PD, ticks, exp_fs_b));
  endtask

  initial begin
    int   a_low_run, a_last_fall, b_low_run, b_last_fall, b_fs_count, b_last_fs;
    logic a_prev_hs, b_prev_vs;
    logic reached;

    $display("[TB] reset with pixelEnable high");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 12'($urandom));

    $display("[TB] free-running pixel clock, sync widths and periods");
    a_low_run = 0; a_last_fall = -1; a_prev_hs = 1'b1;
    b_low_run = 0; b_last_fall = -1; b_prev_vs = 1'b1;
    b_fs_count = 0; b_last_fs = -1;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b0, 1'b1, (i < 1500), 12'h000);
      if (!a_hsync) a_low_run++;
      else if (a_low_run > 0) begin
        checkOutput("hsync_width", 36'(a_low_run), 36'(A_HS));
        a_low_run = 0;
      end
      if (a_prev_hs && !a_hsync) begin
        if (a_last_fall >= 0) checkOutput("line_period", 36'(ticks - a_last_fall), 36'(A_HT));
        a_last_fall = ticks;
      end
      a_prev_hs = a_hsync;
      if (!b_vsync) b_low_run++;
      else if (b_low_run > 0) begin
        checkOutput("vsync_width", 36'(b_low_run), 36'(B_VS * B_HT));
        b_low_run = 0;
      end
      if (b_prev_vs && !b_vsync) begin
        if (b_last_fall >= 0) checkOutput("vsync_period", 36'(ticks - b_last_fall), 36'(B_HT * B_VT));
        b_last_fall = ticks;
      end
      b_prev_vs = b_vsync;
      if (b_fs) begin
        b_fs_count++;
        if (b_last_fs >= 0) checkOutput("frame_period", 36'(ticks - b_last_fs), 36'(B_HT * B_VT));
        b_last_fs = ticks;
      end
    end
    checkOutput("frame_count", 36'(b_fs_count), 36'(3000 / (B_HT * B_VT)));

    $display("[TB] pixelEnable one clock in four");
    for (int i = 0; i < 4000; i++) applyStimulus(1'b0, (i % 4) == 0, 1'b0, 12'($urandom));

    $display("[TB] random enable with occasional reset");
    for (int i = 0; i < 6000; i++)
      applyStimulus($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, 12'($urandom));

    $display("[TB] reset mid-line at column 300");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom));
      if (a_horiz == 10'd300) reached = 1'b1;
    end
    checkOutput("reach_col_300", 36'(a_horiz), 36'd300);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom));
    checkOutput("post_reset_count", 36'({a_horiz, a_vert}), 36'({10'd1, 10'd0}));
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
